// File: rtl/xvc_jtag_shifter_if.sv
// Byte-stream handshakes between the XVC command decoder, the JTAG shift
// engine and the reply packetiser: command, TMS/TDI input and TDO output.
interface xvc_jtag_shifter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_num_bits;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_tms;
  logic [7:0]  in_tdi;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_tdo;

  modport master (
    output cmd_valid, cmd_num_bits, in_valid, in_tms, in_tdi, out_ready,
    input  cmd_ready, in_ready, out_valid, out_tdo
  );

  modport slave (
    input  cmd_valid, cmd_num_bits, in_valid, in_tms, in_tdi, out_ready,
    output cmd_ready, in_ready, out_valid, out_tdo
  );
endinterface

// File: rtl/xvc_jtag_shifter.sv
// JTAG shift engine for one XVC "shift:" command: drives TCK/TMS/TDI and packs TDO.
// Define XVC_SHIFTER_LOOPBACK_EN to sample TDO from the driven TDI (bring-up without a target).
module xvc_jtag_shifter #(
  parameter int TCK_DIV = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  xvc_jtag_shifter_if.slave     bus,
  output logic                  jtag_tck,
  output logic                  jtag_tms,
  output logic                  jtag_tdi,
  input  logic                  jtag_tdo,
  output logic                  busy
);

  localparam int CW = $clog2(TCK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    EMIT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] div_q, div_d;
  logic [7:0]    tms_sr_q, tms_sr_d;
  logic [7:0]    tdi_sr_q, tdi_sr_d;
  logic [7:0]    tdo_q, tdo_d;
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          tdo_bit;

`ifdef XVC_SHIFTER_LOOPBACK_EN
  logic unused_tdo;
  assign unused_tdo = jtag_tdo;
  assign tdo_bit    = tdi_q;
`else
  logic tdo_meta_q, tdo_meta_d;
  logic tdo_sync_q, tdo_sync_d;

  always_comb begin
    tdo_meta_d = jtag_tdo;
    tdo_sync_d = tdo_meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tdo_meta_q <= 1'b0;
      tdo_sync_q <= 1'b0;
    end else begin
      tdo_meta_q <= tdo_meta_d;
      tdo_sync_q <= tdo_sync_d;
    end
  end

  assign tdo_bit = tdo_sync_q;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bit_idx_d   = bit_idx_q;
    div_d       = div_q;
    tms_sr_d    = tms_sr_q;
    tdi_sr_d    = tdi_sr_q;
    tdo_d       = tdo_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          remaining_d = bus.cmd_num_bits;
          state_d     = (bus.cmd_num_bits != 32'd0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          tms_sr_d  = bus.in_tms;
          tdi_sr_d  = bus.in_tdi;
          tms_d     = bus.in_tms[0];
          tdi_d     = bus.in_tdi[0];
          bit_idx_d = 3'd0;
          tdo_d     = 8'h00;
          div_d     = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d            = '0;
          tdo_d[bit_idx_q] = tdo_bit;
          if (remaining_q != 32'd0) begin
            remaining_d = remaining_q - 32'd1;
          end
          bit_idx_d = bit_idx_q + 3'd1;
          // Bit index 7 just completed means the byte is full.
          if (remaining_d == 32'd0 || bit_idx_q == 3'd7) begin
            state_d = EMIT;
          end else begin
            tms_sr_d = tms_sr_q >> 1;
            tdi_sr_d = tdi_sr_q >> 1;
            tms_d    = tms_sr_q[1];
            tdi_d    = tdi_sr_q[1];
            state_d  = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_d = (remaining_q != 32'd0) ? LOAD : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // TCK is registered from the next state so the pin is glitch-free.
    tck_d = (state_d == SHIFT_HI);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 32'd0;
      bit_idx_q   <= 3'd0;
      div_q       <= '0;
      tms_sr_q    <= 8'h00;
      tdi_sr_q    <= 8'h00;
      tdo_q       <= 8'h00;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bit_idx_q   <= bit_idx_d;
      div_q       <= div_d;
      tms_sr_q    <= tms_sr_d;
      tdi_sr_q    <= tdi_sr_d;
      tdo_q       <= tdo_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_tdo   = tdo_q;
  assign jtag_tck      = tck_q;
  assign jtag_tms      = tms_q;
  assign jtag_tdi      = tdi_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/xvc_jtag_shifter.md
# xvc_jtag_shifter

JTAG shift engine for the XVC microserver: executes the payload of one XVC `shift:` command by clocking TMS/TDI vectors onto the JTAG pins and collecting TDO into a byte stream. Sits downstream of the XVC command decoder, which consumes the Ethernet payload from the PCS/PMA path, and upstream of the reply packetiser. One command is in flight at a time. Byte streams use valid/ready handshakes.

## Interface
- `TCK_DIV`, default 5: system clocks per TCK half-period. Legal range ≥ 3.
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  new shift command present
- `cmd_ready`  out  1  engine idle, command accepted on `cmd_valid & cmd_ready`
- `cmd_num_bits`  in  32  number of bits to shift, 0 is legal
- `in_valid`  in  1  TMS/TDI byte pair present
- `in_ready`  out  1  byte pair consumed on `in_valid & in_ready`
- `in_tms`  in  8  TMS bits, LSB shifted first
- `in_tdi`  in  8  TDI bits, LSB shifted first
- `out_valid`  out  1  TDO byte present
- `out_ready`  in  1  downstream accepts TDO byte
- `out_tdo`  out  8  captured TDO, LSB = first bit
- `jtag_tck`, `jtag_tms`, `jtag_tdi`  out  1 each  JTAG pins
- `jtag_tdo`  in  1  JTAG TDO pin, asynchronous
- `busy`  out  1  high from command acceptance until return to IDLE

## Operation
- States:
  - IDLE. `cmd_ready` = 1. On accept, latch `remaining` = `cmd_num_bits`. Go to LOAD if non-zero, otherwise DONE.
  - LOAD. `in_ready` = 1. On handshake, latch TMS/TDI bytes and set bit index 0. Go to SHIFT_LO.
  - SHIFT_LO. Drive `jtag_tms`/`jtag_tdi` from the current bit with TCK low for `TCK_DIV` clocks. Go to SHIFT_HI.
  - SHIFT_HI. TCK high for `TCK_DIV` clocks. On the last clock, sample synchronised TDO into the bit index, then decrement `remaining` and increment the bit index.
    - If `remaining` = 0 or bit index = 8, go to EMIT.
    - Otherwise go to SHIFT_LO.
  - EMIT. `out_valid` = 1 with the TDO byte. Unshifted upper bits are 0. On handshake, go to LOAD if `remaining` ≠ 0, otherwise DONE.
  - DONE. Lasts one cycle, then IDLE.
- Pins during stalls: TCK stays low in LOAD and EMIT. TMS/TDI hold their last driven values.
- TDO synchroniser: `jtag_tdo` passes through a 2-flop synchroniser before sampling.
- Partial final byte: input bits above the residual count are ignored.
- Counters: `remaining` is 32-bit unsigned and never wraps, because decrement happens only when it is non-zero. The half-period counter is `$clog2(TCK_DIV)` bits wide.
- Input rule: `cmd_valid` while busy is ignored. The upstream block holds it.

## Timing
- Reset values, all outputs: `jtag_tck`/`jtag_tms`/`jtag_tdi` = 0, `out_valid` = 0, `out_tdo` = 0, `in_ready` = 0, `busy` = 0.
- `cmd_ready` is `state == IDLE && !reset`. It is 1 in the first cycle after reset deasserts.
- `busy` rises the cycle after command accept.
- Per bit: exactly 2·`TCK_DIV` clocks. TCK has a 50 % duty cycle.
- Full byte, no stalls: 1 (LOAD) + 16·`TCK_DIV` + 1 (EMIT) clocks.
- `num_bits` = 0: accept, then DONE, then IDLE. `busy` is high for 1 cycle. No `in_ready`, no `out_valid`.
- Output registers: `out_tdo`/`out_valid` are registered and stable while `out_valid & !out_ready`.
- Reset mid-operation: next cycle returns to IDLE with reset values on all outputs. The partial byte is dropped and not emitted.

## Configuration
- `XVC_SHIFTER_LOOPBACK_EN` defined: the TDO sample is taken from the internal registered `jtag_tdi` instead of the synchronised `jtag_tdo` pin. `jtag_tdo` is unused. This mode is for board bring-up without a target.
- Not defined: TDO comes from the pin through the 2-flop synchroniser.

## Test plan
- Loopback, `TCK_DIV`=3, `num_bits`=8, tms=0x00, tdi=0xA5 → one `out_tdo`=0xA5; 8 TCK pulses, each 6 clocks; `jtag_tms` stays 0.
- Loopback, `num_bits`=12, bytes (tdi 0x3C, tms 0x00) then (tdi 0xF5, tms 0x0F) → outputs 0x3C then 0x05; 12 TCK pulses; TMS high on pulses 9–12.
- `num_bits`=0 → cmd accepted, `busy` high 1 cycle, no `in_ready`, no `out_valid`, `cmd_ready` back within 3 cycles.
- Pin mode, `jtag_tdo` tied 1, `num_bits`=8 → `out_tdo`=0xFF. With `out_ready` low for 20 cycles: TCK low, `in_ready` low, `out_tdo` stable; completes after `out_ready` rises.
- Reset asserted during the 4th bit of a 16-bit command → next cycle all outputs 0, `cmd_ready`=1 after release, no stale `out_valid`. A following 8-bit command runs correctly.
